// File: rtl/alu_uart_sequencer_pkg.sv
// Shared definitions for the ALU/UART sequencer: one-hot FSM encoding and
// default widths used by the interface and the sequencer.
package alu_uart_sequencer_pkg;

    localparam int DEFAULT_DATA_BITS   = 8;
    localparam int DEFAULT_OPCODE_BITS = 6;
    localparam int STATE_BITS          = 6;

    // One-hot frame sequencing states.
    typedef enum logic [STATE_BITS-1:0] {
        S_GET_A   = 6'b000001,
        S_GET_B   = 6'b000010,
        S_GET_OP  = 6'b000100,
        S_EXEC    = 6'b001000,
        S_SEND    = 6'b010000,
        S_WAIT_TX = 6'b100000
    } state_t;

    // True while a frame is being executed or transmitted (rx bytes are dropped).
    function automatic logic state_is_busy(input state_t s);
        return (s == S_EXEC) || (s == S_SEND) || (s == S_WAIT_TX);
    endfunction

    // True while collecting the second or third byte of a frame.
    function automatic logic state_is_mid_frame(input state_t s);
        return (s == S_GET_B) || (s == S_GET_OP);
    endfunction

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// Bus between the sequencer and its UART receiver/transmitter and ALU.
//
// Handshake semantics: i_rx_valid is a one-cycle push with no back-pressure;
// a byte offered while the sequencer is busy is dropped and reported one
// cycle later on o_overrun. o_tx_start is a one-cycle request; o_tx_data is
// held stable from o_tx_start until the transmitter returns the one-cycle
// i_tx_done pulse. i_alu_result is combinational from the operand/opcode
// outputs.
interface alu_uart_sequencer_if
    import alu_uart_sequencer_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int OPCODE_BITS = DEFAULT_OPCODE_BITS
) ();

    logic                   i_rx_valid;
    logic [DATA_BITS-1:0]   i_rx_data;
    logic [DATA_BITS-1:0]   i_alu_result;
    logic                   i_tx_done;
    logic [DATA_BITS-1:0]   o_operand_a;
    logic [DATA_BITS-1:0]   o_operand_b;
    logic [OPCODE_BITS-1:0] o_opcode;
    logic                   o_tx_start;
    logic [DATA_BITS-1:0]   o_tx_data;
    logic                   o_busy;
    logic                   o_overrun;
    logic                   o_frame_error;

    // Sequencer side.
    modport slave (
        input  i_rx_valid, i_rx_data, i_alu_result, i_tx_done,
        output o_operand_a, o_operand_b, o_opcode, o_tx_start, o_tx_data,
               o_busy, o_overrun, o_frame_error
    );

    // UART/ALU environment side.
    modport master (
        output i_rx_valid, i_rx_data, i_alu_result, i_tx_done,
        input  o_operand_a, o_operand_b, o_opcode, o_tx_start, o_tx_data,
               o_busy, o_overrun, o_frame_error
    );

endinterface

// File: rtl/alu_uart_sequencer_frame_timer.sv
// frame_timer: inter-byte timeout counter. Counts enabled cycles since the
// last clear and raises expire combinationally on the TIMEOUT_CYCLES-th one.
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(TIMEOUT_CYCLES - 1);

    logic [CNT_BITS-1:0] count;

    assign expire = enable && (count == LAST_COUNT);

    // Counter restarts on clear or on expiry so it never wraps past LAST_COUNT.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects operand A, operand B and opcode bytes from a
// UART receiver, presents them to an external ALU, and sends the result byte
// back through a UART transmitter.
//
// Build option: define ALU_UART_SEQ_TIMEOUT_EN to abandon a partial frame when
// no byte arrives within TIMEOUT_CYCLES clocks while waiting for B or opcode.
module alu_uart_sequencer
    import alu_uart_sequencer_pkg::*;
#(
    parameter int DATA_BITS      = DEFAULT_DATA_BITS,
    parameter int OPCODE_BITS    = DEFAULT_OPCODE_BITS,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    alu_uart_sequencer_if.slave  bus,
    output state_t               dbg_state
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t state;
    state_t state_next;

    logic [DATA_BITS-1:0]   operand_a;
    logic [DATA_BITS-1:0]   operand_b;
    logic [OPCODE_BITS-1:0] opcode;
    logic [DATA_BITS-1:0]   tx_data;
    logic                   overrun_q;
    logic                   frame_error_q;

    logic load_a;
    logic load_b;
    logic load_op;
    logic load_result;
    logic rx_accept;
    logic rx_drop;
    logic tx_start;
    logic busy;
    logic timeout_fire;
    logic timer_expire;

`ifdef ALU_UART_SEQ_TIMEOUT_EN
    logic timer_enable;
    logic timer_clear;

    // The timer only runs while a frame is half collected and restarts on every accepted byte.
    assign timer_enable = state_is_mid_frame(state);
    assign timer_clear  = rx_accept || !timer_enable;

    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expire  (timer_expire)
    );
`else
    assign timer_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= S_GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_GET_A: begin
                if (bus.i_rx_valid) state_next = S_GET_B;
            end
            S_GET_B: begin
                if (bus.i_rx_valid)    state_next = S_GET_OP;
                else if (timer_expire) state_next = S_GET_A;
            end
            S_GET_OP: begin
                if (bus.i_rx_valid)    state_next = S_EXEC;
                else if (timer_expire) state_next = S_GET_A;
            end
            S_EXEC:    state_next = S_SEND;
            S_SEND:    state_next = S_WAIT_TX;
            S_WAIT_TX: begin
                if (bus.i_tx_done) state_next = S_GET_A;
            end
            default:   state_next = S_GET_A;
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        load_a       = (state == S_GET_A)  && bus.i_rx_valid;
        load_b       = (state == S_GET_B)  && bus.i_rx_valid;
        load_op      = (state == S_GET_OP) && bus.i_rx_valid;
        load_result  = (state == S_EXEC);
        rx_accept    = load_a || load_b || load_op;
        busy         = state_is_busy(state);
        rx_drop      = busy && bus.i_rx_valid;
        tx_start     = (state == S_SEND);
        timeout_fire = timer_expire && !bus.i_rx_valid && state_is_mid_frame(state);
    end

    // Operand, opcode and result registers hold until overwritten by a new accepted byte or result.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            operand_a <= '0;
            operand_b <= '0;
            opcode    <= '0;
            tx_data   <= '0;
        end else begin
            if (load_a)      operand_a <= bus.i_rx_data;
            if (load_b)      operand_b <= bus.i_rx_data;
            if (load_op)     opcode    <= bus.i_rx_data[OPCODE_BITS-1:0];
            if (load_result) tx_data   <= bus.i_alu_result;
        end
    end

    // Status pulses are registered so they appear the cycle after the event.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            overrun_q     <= rx_drop;
            frame_error_q <= timeout_fire;
        end
    end

    assign bus.o_operand_a   = operand_a;
    assign bus.o_operand_b   = operand_b;
    assign bus.o_opcode      = opcode;
    assign bus.o_tx_data     = tx_data;
    assign bus.o_tx_start    = tx_start;
    assign bus.o_busy        = busy;
    assign bus.o_overrun     = overrun_q;
    assign bus.o_frame_error = frame_error_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Testbench for alu_uart_sequencer. The reference model tracks frames as
// byte lists with cycle stamps; expected transmissions, overrun pulses and
// frame errors go into queues that a negedge monitor drains.
module tb_alu_uart_sequencer;
    import alu_uart_sequencer_pkg::*;

    localparam int DW    = 8;
    localparam int OW    = 6;
    localparam int T     = 16;
    localparam int NEVER = 32'h7fff_ffff;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t dbg_state;
    int     cyc = 0;

    alu_uart_sequencer_if #(.DATA_BITS(DW), .OPCODE_BITS(OW)) bus ();

    alu_uart_sequencer #(
        .DATA_BITS      (DW),
        .OPCODE_BITS    (OW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- external ALU stand-in ----------------
    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OW-1:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return ~(a ^ b) + {2'b00, op};
        endcase
    endfunction

    assign bus.i_alu_result = alu_ref(bus.o_operand_a, bus.o_operand_b, bus.o_opcode);

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
        int            at;
    } tx_exp_t;

    tx_exp_t exp_q[$];
    int      ovr_q[$];
    int      ferr_q[$];
    int      n_cmp = 0;
    int      n_err = 0;

    // Reference model: bytes collected so far, latched frame values, busy window.
    int            pos      = 0;
    int            last_acc = 0;
    int            busy_lo  = 1;
    int            busy_hi  = 0;
    logic [DW-1:0] ma       = '0;
    logic [DW-1:0] mb       = '0;
    logic [OW-1:0] mop      = '0;
    bit            hold_active = 1'b0;
    logic [DW-1:0] hold_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_busy(input int c);
        return (c >= busy_lo) && (c <= busy_hi);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
`ifdef ALU_UART_SEQ_TIMEOUT_EN
        if (pos != 0 && cyc == last_acc + T + 1) begin
            ferr_q.push_back(cyc);
            pos = 0;
        end
`endif
    endtask

    task automatic accept(input logic [DW-1:0] d);
        tx_exp_t e;
        case (pos)
            0: begin ma = d; pos = 1; end
            1: begin mb = d; pos = 2; end
            default: begin
                mop    = d[OW-1:0];
                pos    = 0;
                e.data = alu_ref(ma, mb, mop);
                e.a    = ma;
                e.b    = mb;
                e.op   = mop;
                e.at   = cyc + 2;
                exp_q.push_back(e);
                busy_lo = cyc + 1;
                busy_hi = NEVER;
            end
        endcase
        last_acc = cyc;
    endtask

    task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input bit done);
        if (v) begin
            if (in_busy(cyc)) ovr_q.push_back(cyc + 1);
            else accept(d);
        end
        if (done && busy_hi == NEVER && cyc >= busy_lo + 2) busy_hi = cyc;
        bus.i_rx_valid = v;
        bus.i_rx_data  = v ? d : DW'($urandom);
        bus.i_tx_done  = done;
        tick();
        bus.i_rx_valid = 1'b0;
        bus.i_tx_done  = 1'b0;
    endtask

    task automatic idle(input int n, input bit allow_done);
        repeat (n) drive_cycle(1'b0, '0, allow_done && ($urandom_range(0, 7) == 0));
    endtask

    task automatic send_byte(input logic [DW-1:0] d, input int gap);
        idle(gap, 1'b1);
        drive_cycle(1'b1, d, 1'b0);
    endtask

    task automatic complete_tx(input int wait_cyc, input int ovr_off, input logic [DW-1:0] ovr_byte,
                               input bit spurious);
        int op_cyc;
        int target;
        int ovr_at;
        op_cyc = busy_lo - 1;
        target = op_cyc + 3 + wait_cyc;
        ovr_at = (ovr_off > 0) ? op_cyc + ovr_off : -1;
        while (cyc <= target)
            drive_cycle(cyc == ovr_at, ovr_byte, (cyc == target) || (spurious && cyc == op_cyc + 2));
    endtask

    task automatic finish_if_busy(input int wait_cyc, input int ovr_off, input logic [DW-1:0] ovr_byte,
                                  input bit spurious);
        if (busy_hi == NEVER) complete_tx(wait_cyc, ovr_off, ovr_byte, spurious);
    endtask

    task automatic frame(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] op,
                         input int ga, input int gb, input int go, input int wait_cyc,
                         input int ovr_off, input logic [DW-1:0] ovr_byte, input bit spurious);
        send_byte(a, ga);  finish_if_busy(wait_cyc, ovr_off, ovr_byte, spurious);
        send_byte(b, gb);  finish_if_busy(wait_cyc, ovr_off, ovr_byte, spurious);
        send_byte(op, go); finish_if_busy(wait_cyc, ovr_off, ovr_byte, spurious);
    endtask

    task automatic check_reset_outputs();
        check("rst_operand_a", 32'(bus.o_operand_a), 32'(0));
        check("rst_operand_b", 32'(bus.o_operand_b), 32'(0));
        check("rst_opcode", 32'(bus.o_opcode), 32'(0));
        check("rst_tx_data", 32'(bus.o_tx_data), 32'(0));
        check("rst_tx_start", 32'(bus.o_tx_start), 32'(0));
        check("rst_busy", 32'(bus.o_busy), 32'(0));
        check("rst_overrun", 32'(bus.o_overrun), 32'(0));
        check("rst_frame_error", 32'(bus.o_frame_error), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(S_GET_A));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        ovr_q.delete();
        ferr_q.delete();
        pos = 0; busy_lo = 1; busy_hi = 0;
        ma = '0; mb = '0; mop = '0;
        hold_active = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_done  = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [DW-1:0] pick_op();
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0: return {2'($urandom), 6'h20};
            1: return {2'($urandom), 6'h22};
            2: return {2'($urandom), 6'h24};
            3: return {2'($urandom), 6'h25};
            4: return {2'($urandom), 6'h26};
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic int rand_gap();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 2);
        if (r < 9) return $urandom_range(T - 2, T + 1);
        return $urandom_range(3, 5);
    endfunction

    // ---------------- monitor ----------------
    // Compares every cycle's outputs against the queued expectations.
    always @(negedge clk) begin
        tx_exp_t e;
        if (!rst) begin
            check("busy", 32'(bus.o_busy), 32'(in_busy(cyc)));

            if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                check("tx_start", 32'(bus.o_tx_start), 32'(1));
                check("tx_data", 32'(bus.o_tx_data), 32'(e.data));
                check("operand_a", 32'(bus.o_operand_a), 32'(e.a));
                check("operand_b", 32'(bus.o_operand_b), 32'(e.b));
                check("opcode", 32'(bus.o_opcode), 32'(e.op));
                hold_active = 1'b1;
                hold_val    = e.data;
            end else begin
                check("tx_start_idle", 32'(bus.o_tx_start), 32'(0));
                if (hold_active) begin
                    if (cyc <= busy_hi) check("tx_data_hold", 32'(bus.o_tx_data), 32'(hold_val));
                    else hold_active = 1'b0;
                end
            end

            if (ovr_q.size() != 0 && ovr_q[0] == cyc) begin
                void'(ovr_q.pop_front());
                check("overrun", 32'(bus.o_overrun), 32'(1));
                check("ovr_keep_a", 32'(bus.o_operand_a), 32'(ma));
                check("ovr_keep_b", 32'(bus.o_operand_b), 32'(mb));
                check("ovr_keep_op", 32'(bus.o_opcode), 32'(mop));
            end else begin
                check("overrun_idle", 32'(bus.o_overrun), 32'(0));
            end

            if (ferr_q.size() != 0 && ferr_q[0] == cyc) begin
                void'(ferr_q.pop_front());
                check("frame_error", 32'(bus.o_frame_error), 32'(1));
                check("ferr_state", 32'(dbg_state), 32'(S_GET_A));
            end else begin
                check("frame_error_idle", 32'(bus.o_frame_error), 32'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;
        bus.i_tx_done  = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        check_reset_outputs();
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();

        // ADD frame with a settled wait for the transmitter.
        frame(8'h05, 8'h03, 8'h20, 0, 1, 0, 3, 0, '0, 1'b0);
        // Byte 0x11 dropped in WAIT_TX, then an ordinary frame.
        frame(8'h40, 8'h0C, 8'h26, 2, 0, 0, 3, 4, 8'h11, 1'b0);
        frame(8'h40, 8'h0C, 8'h22, 0, 0, 0, 1, 0, '0, 1'b0);
        // Back-to-back frames, stray tx_done during SEND.
        frame(8'h10, 8'h20, 8'h20, 0, 0, 0, 0, 0, '0, 1'b1);
        frame(8'h7F, 8'h81, 8'h25, 0, 0, 0, 2, 1, 8'h5A, 1'b1);

`ifdef ALU_UART_SEQ_TIMEOUT_EN
        // Abandoned frame: 0xAA then 20 idle cycles, then a clean frame.
        send_byte(8'hAA, 0);
        idle(20, 1'b1);
        frame(8'h09, 8'h04, 8'h22, 0, 0, 0, 1, 0, '0, 1'b0);
        // Byte on the exact expiry cycle is accepted.
        frame(8'h33, 8'h44, 8'h24, 0, T - 1, T - 1, 1, 0, '0, 1'b0);
        // One cycle later it is too late: the byte starts a new frame.
        frame(8'h55, 8'h66, 8'h77, 0, T, 0, 1, 0, '0, 1'b0);
        frame(8'h20, 8'h01, 8'h02, 0, 0, 0, 1, 0, '0, 1'b0);
`else
        // Without the timeout a long pause mid-frame is harmless.
        frame(8'h21, 8'h07, 8'h24, 0, 20, 3, 1, 0, '0, 1'b0);
`endif

        // Reset while waiting for the transmitter.
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h20, 0);
        idle(3, 1'b0);
        do_reset();
        // Reset while collecting the opcode.
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        do_reset();
        frame(8'h0F, 8'h01, 8'h22, 0, 0, 0, 2, 0, '0, 1'b0);

        // Randomized frames.
        for (int i = 0; i < 60; i++) begin
            int w;
            int oo;
            w  = $urandom_range(0, 4);
            oo = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3 + w)) : 0;
            frame(DW'($urandom), DW'($urandom), pick_op(), rand_gap(), rand_gap(), rand_gap(),
                  w, oo, DW'($urandom), $urandom_range(0, 3) == 0);
        end
        finish_if_busy(1, 0, '0, 1'b0);

        idle(T + 4, 1'b0);
        check("tx_queue_drained", 32'(exp_q.size()), 32'(0));
        check("ovr_queue_drained", 32'(ovr_q.size()), 32'(0));
        check("ferr_queue_drained", 32'(ferr_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_uart_sequencer.md
ALU_UART_SEQUENCER -- requirements
Module: alu_uart_sequencer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, UART byte and ALU operand/result width.
REQ-002 SHALL have parameter OPCODE_BITS, default 6, ALU opcode width; opcode = low OPCODE_BITS of opcode byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, inter-byte frame timeout in clock cycles (min 2).
REQ-004 i_clock  in  1  clock; all state updates on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_rx_valid  in  1  one-cycle pulse: UART receiver has a byte on i_rx_data.
REQ-007 i_rx_data  in  DATA_BITS  received byte, valid only with i_rx_valid.
REQ-008 i_alu_result  in  DATA_BITS  combinational ALU result for current operands/opcode.
REQ-009 i_tx_done  in  1  one-cycle pulse: UART transmitter finished the byte.
REQ-010 o_operand_a / o_operand_b  out  DATA_BITS  registered operands to ALU.
REQ-011 o_opcode  out  OPCODE_BITS  registered opcode to ALU.
REQ-012 o_tx_start  out  1  one-cycle transmit request.
REQ-013 o_tx_data  out  DATA_BITS  registered result byte, stable from o_tx_start until i_tx_done.
REQ-014 o_busy  out  1  high in EXEC, SEND, WAIT_TX.
REQ-015 o_overrun  out  1  one-cycle pulse when an rx byte is dropped.
REQ-016 o_frame_error  out  1  one-cycle pulse on frame timeout (0 when timeout compiled out).

Function
REQ-017 FSM states SHALL be GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
REQ-018 GET_A + i_rx_valid: o_operand_a <= i_rx_data, -> GET_B; GET_B likewise -> o_operand_b, -> GET_OP.
REQ-019 GET_OP + i_rx_valid: o_opcode <= i_rx_data[OPCODE_BITS-1:0], -> EXEC.
REQ-020 EXEC: o_tx_data <= i_alu_result, -> SEND unconditionally (one cycle).
REQ-021 SEND: o_tx_start high exactly this cycle, -> WAIT_TX.
REQ-022 WAIT_TX: hold until i_tx_done, then -> GET_A; i_tx_done outside WAIT_TX ignored.
REQ-023 Latency: opcode byte accepted at edge N -> o_tx_start high in cycle N+2.
REQ-024 i_rx_valid in EXEC/SEND/WAIT_TX: byte dropped, o_overrun pulses next cycle, registers unchanged.
REQ-025 Operand/opcode registers SHALL hold value between frames; only overwritten by new accepted bytes.
REQ-026 Back-to-back frames: byte in cycle after i_tx_done accepted as new operand A.

Reset
REQ-027 Async reset SHALL force state GET_A, operands/opcode/o_tx_data 0, all pulse outputs 0, timeout counter 0.
REQ-028 Reset mid-frame or mid-transmit SHALL discard the frame; no o_tx_start issued afterwards for it.

Configuration
REQ-029 Macro ALU_UART_SEQ_TIMEOUT_EN defined: counter clears on each accepted byte, counts in GET_B/GET_OP; at TIMEOUT_CYCLES-1 without a byte -> GET_A, o_frame_error pulses one cycle.
REQ-030 Timeout expiry and i_rx_valid same cycle: byte wins, accepted normally, no error.
REQ-031 Macro undefined: no counter logic, GET_B/GET_OP wait indefinitely, o_frame_error tied 0.

Structure
REQ-032 Shared package SHALL hold FSM state encoding (one-hot, 6 bits) and default DATA_BITS/OPCODE_BITS constants.
REQ-033 Timeout counter SHALL be sub-module frame_timer (clear, enable, expire pulse), instantiated only under the macro.

Verification
REQ-034 Bytes 0x05,0x03,0x20 (ADD), ALU gives 0x08 -> o_tx_start 2 cycles after opcode edge, o_tx_data=0x08, o_busy high until i_tx_done.
REQ-035 Byte 0x11 during WAIT_TX -> o_overrun one pulse, o_operand_a unchanged, next frame correct.
REQ-036 Macro on, TIMEOUT_CYCLES=16: send 0xAA then idle 20 cycles -> o_frame_error pulse, state GET_A, next 3 bytes form valid frame.
REQ-037 Macro on: byte arrives on exact expiry cycle -> accepted, no o_frame_error.
REQ-038 Assert i_reset in WAIT_TX and in GET_OP -> all outputs 0, no o_tx_start, fresh frame 0x0F,0x01,0x22 succeeds.
REQ-039 Two frames back-to-back, second A byte in cycle after i_tx_done -> both results transmitted in order.
